// File: rtl/riscv_dcache_pkg.sv
// Shared types and constants for the RV64 data-cache controller and its arrays.
package riscv_dcache_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        ALLOCATE   = 2'd2,
        FILL       = 2'd3
    } dcache_state_t;

    // Memory address mux select: victim line vs. the CPU's own line.
    localparam logic ADDR_SEL_VICTIM = 1'b1;
    localparam logic ADDR_SEL_CPU    = 1'b0;

    // Geometry defaults shared with the data and tag arrays.
    localparam int DEFAULT_INDEX = 12;
    localparam int DEFAULT_TAG   = 48;

endpackage

// File: rtl/riscv_dcache_fsm.sv
// Data-cache controller: serves hits, runs write-back/allocate/fill on misses.
// Optional perf counters (hit_cnt/miss_cnt) are built when DCACHE_PERF_CNT_EN is defined.
module riscv_dcache_fsm
    import riscv_dcache_pkg::*;
#(
    parameter int INDEX = DEFAULT_INDEX,
    parameter int TAG   = DEFAULT_TAG,
    parameter int CNT_W = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_rden,
    input  logic cpu_wren,
    input  logic cache_hit,
    input  logic victim_dirty,
    input  logic mem_ready,
    output logic stall,
    output logic data_rden,
    output logic data_wren,
    output logic mem_in,
    output logic tag_wren,
    output logic set_dirty,
    output logic addr_sel,
    output logic mem_rden,
    output logic mem_wren
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
`endif
);

    dcache_state_t state_reg;
    dcache_state_t state_next;

    logic req;
    assign req = cpu_rden | cpu_wren;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // IDLE decodes the live request so a hit costs no stall and a miss stalls at once.
    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        data_rden  = 1'b0;
        data_wren  = 1'b0;
        mem_in     = 1'b0;
        tag_wren   = 1'b0;
        set_dirty  = 1'b0;
        addr_sel   = ADDR_SEL_CPU;
        mem_rden   = 1'b0;
        mem_wren   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (cache_hit) begin
                        // A simultaneous load and store request is served as a load.
                        if (cpu_rden) begin
                            data_rden = 1'b1;
                        end else begin
                            data_wren = 1'b1;
                            set_dirty = 1'b1;
                        end
                    end else begin
                        stall      = 1'b1;
                        state_next = victim_dirty ? WRITE_BACK : ALLOCATE;
                    end
                end
            end
            WRITE_BACK: begin
                stall     = 1'b1;
                mem_wren  = 1'b1;
                addr_sel  = ADDR_SEL_VICTIM;
                data_rden = 1'b1;
                if (mem_ready) begin
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                stall    = 1'b1;
                mem_rden = 1'b1;
                if (mem_ready) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                stall      = 1'b1;
                data_wren  = 1'b1;
                mem_in     = 1'b1;
                tag_wren   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef DCACHE_PERF_CNT_EN
    logic hit_evt;
    logic miss_evt;
    assign hit_evt  = (state_reg == IDLE) && req && cache_hit;
    assign miss_evt = (state_reg == IDLE) && req && !cache_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_evt) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (miss_evt) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end
`else
    // Counters not built: the controller is the FSM alone.
`endif

endmodule
